// File: rtl/x86_length_decoder.sv
// x86_length_decoder
// Sequential length pre-decoder for 64-bit-mode x86 instructions. A fetch
// window that begins at an instruction boundary is latched and walked one
// field per cycle: legacy prefixes, REX, opcode (with 0F escape), ModRM, SIB,
// displacement and immediate. The length and decoded fields are then held
// until the consumer takes them.
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous active-low reset
//   in_bytes        fetch window, byte i at bits [8*i : 8*i+7]
//   in_valid        window valid
//   in_ready        block idle and able to take a window
//   out_valid       decode result valid
//   out_ready       consumer accepts result
//   out_len         instruction length in bytes
//   out_prefix_mask F0, F2, F3, segment override, 66, 67 (bits 0..5)
//   out_rex         REX W,R,X,B (0 when no REX)
//   out_opcode      {0F escape, opcode byte}
//   out_modrm       ModRM byte (0 when absent)
//   out_illegal     unsupported opcode, prefix overflow or window overrun
module x86_length_decoder #(
    parameter int WINDOW_BYTES = 15,
    parameter int MAX_PREFIXES = 4,
    parameter int LEN_W        = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [0:8*WINDOW_BYTES-1]   in_bytes,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LEN_W-1:0]            out_len,
    output logic [5:0]                  out_prefix_mask,
    output logic [3:0]                  out_rex,
    output logic [8:0]                  out_opcode,
    output logic [7:0]                  out_modrm,
    output logic                        out_illegal
);

    localparam int PW = LEN_W + 1;
    localparam logic [PW-1:0]    WIN_EXT = PW'(WINDOW_BYTES);
    localparam logic [PW-1:0]    MAX_EXT = PW'(MAX_PREFIXES);
    localparam logic [PW-1:0]    ONE_PW  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] PTR_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_PREFIX  = 4'd1,
        ST_OPCODE  = 4'd2,
        ST_OPCODE2 = 4'd3,
        ST_MODRM   = 4'd4,
        ST_SIB     = 4'd5,
        ST_DISP    = 4'd6,
        ST_IMM     = 4'd7,
        ST_DONE    = 4'd8
    } state_t;

    typedef struct packed {
        logic       legal;
        logic       has_modrm;
        logic [3:0] imm;
    } opc_class_t;

    // Mask bit contributed by a legacy prefix byte; zero for anything else.
    function automatic logic [5:0] prefix_bit(input logic [7:0] b);
        case (b)
            8'hF0:                                    prefix_bit = 6'b000001;
            8'hF2:                                    prefix_bit = 6'b000010;
            8'hF3:                                    prefix_bit = 6'b000100;
            8'h2E, 8'h36, 8'h3E, 8'h26, 8'h64, 8'h65: prefix_bit = 6'b001000;
            8'h66:                                    prefix_bit = 6'b010000;
            8'h67:                                    prefix_bit = 6'b100000;
            default:                                  prefix_bit = 6'b000000;
        endcase
    endfunction

    // One-byte opcode map. Immediates of the "z" form shrink to 2 with 66;
    // MOV r64, imm64 (B8-BF with REX.W) is the only 8-byte immediate.
    function automatic opc_class_t classify_opcode(input logic [7:0] op,
                                                   input logic opsize,
                                                   input logic rex_w);
        opc_class_t c;
        logic [3:0] imm_z;
        imm_z       = opsize ? 4'd2 : 4'd4;
        c.legal     = 1'b1;
        c.has_modrm = 1'b0;
        c.imm       = 4'd0;
        if (op[7:6] == 2'b00) begin
            case (op[2:0])
                3'd0, 3'd1, 3'd2, 3'd3: c.has_modrm = 1'b1;
                3'd4:                   c.imm = 4'd1;
                3'd5:                   c.imm = imm_z;
                default:                c.legal = 1'b0;
            endcase
        end else begin
            casez (op)
                8'h80, 8'h83, 8'hC6: begin c.has_modrm = 1'b1; c.imm = 4'd1; end
                8'h81, 8'hC7:        begin c.has_modrm = 1'b1; c.imm = imm_z; end
                8'h88, 8'h89, 8'h8A, 8'h8B, 8'h8D: c.has_modrm = 1'b1;
                8'b1011_0???:        c.imm = 4'd1;
                8'b1011_1???:        c.imm = rex_w ? 4'd8 : imm_z;
                8'b0111_????, 8'hEB: c.imm = 4'd1;
                8'hE8, 8'hE9:        c.imm = 4'd4;
                8'b0101_????, 8'h90, 8'hC3: c.imm = 4'd0;
                default:             c.legal = 1'b0;
            endcase
        end
        return c;
    endfunction

    // First field still to be consumed once ModRM/SIB are done.
    function automatic state_t after_operands(input logic [3:0] disp, input logic [3:0] imm);
        if (disp != 4'd0) begin
            return ST_DISP;
        end else if (imm != 4'd0) begin
            return ST_IMM;
        end else begin
            return ST_DONE;
        end
    endfunction

    state_t           state_r, state_n;
    logic [7:0]       win_r [WINDOW_BYTES];
    logic [LEN_W-1:0] ptr_r, ptr_n;
    logic [PW-1:0]    pcount_r, pcount_n;
    logic [5:0]       mask_r, mask_n;
    logic [3:0]       rex_r, rex_n;
    logic [8:0]       opcode_r, opcode_n;
    logic [7:0]       modrm_r, modrm_n;
    logic             illegal_r, illegal_n;
    logic [3:0]       disp_r, disp_n;
    logic [3:0]       imm_r, imm_n;

    logic [7:0]       cur_byte_s;
    logic             byte_avail_s;
    logic             overrun_s;
    logic [5:0]       pfx_bit_s;
    opc_class_t       opc_class_s;
    logic [3:0]       modrm_disp_s;
    logic [3:0]       sib_disp_s;
    logic [PW-1:0]    disp_end_s;
    logic [PW-1:0]    imm_end_s;

    logic             in_ready_r, out_valid_r, out_illegal_r;
    logic [LEN_W-1:0] out_len_r;
    logic [5:0]       out_mask_r;
    logic [3:0]       out_rex_r;
    logic [8:0]       out_opcode_r;
    logic [7:0]       out_modrm_r;

    // Byte under the pointer; reads past the window yield zero.
    always_comb begin
        cur_byte_s = 8'h00;
        for (int i = 0; i < WINDOW_BYTES; i++) begin
            if (ptr_r == LEN_W'(i)) begin
                cur_byte_s = win_r[i];
            end else begin
                cur_byte_s = cur_byte_s;
            end
        end
    end

    // Per-byte field decode and end-of-field positions for the pointer.
    always_comb begin
        byte_avail_s = ({1'b0, ptr_r} < WIN_EXT);
        pfx_bit_s    = prefix_bit(cur_byte_s);
        opc_class_s  = classify_opcode(cur_byte_s, mask_r[4], rex_r[3]);
        case (cur_byte_s[7:6])
            2'b01:   modrm_disp_s = 4'd1;
            2'b10:   modrm_disp_s = 4'd4;
            2'b00:   modrm_disp_s = (cur_byte_s[2:0] == 3'b101) ? 4'd4 : 4'd0;
            default: modrm_disp_s = 4'd0;
        endcase
        // SIB base 101 under mod 00 means "no base, disp32".
        if ((cur_byte_s[2:0] == 3'b101) && (modrm_r[7:6] == 2'b00)) begin
            sib_disp_s = 4'd4;
        end else begin
            sib_disp_s = disp_r;
        end
        disp_end_s = {1'b0, ptr_r} + PW'(disp_r);
        imm_end_s  = {1'b0, ptr_r} + PW'(imm_r);
    end

    // Next-state and field-register update for the byte walk.
    always_comb begin
        state_n   = state_r;
        ptr_n     = ptr_r;
        pcount_n  = pcount_r;
        mask_n    = mask_r;
        rex_n     = rex_r;
        opcode_n  = opcode_r;
        modrm_n   = modrm_r;
        illegal_n = illegal_r;
        disp_n    = disp_r;
        imm_n     = imm_r;
        overrun_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_n   = ST_PREFIX;
                    ptr_n     = {LEN_W{1'b0}};
                    pcount_n  = {PW{1'b0}};
                    mask_n    = 6'd0;
                    rex_n     = 4'd0;
                    opcode_n  = 9'd0;
                    modrm_n   = 8'd0;
                    illegal_n = 1'b0;
                    disp_n    = 4'd0;
                    imm_n     = 4'd0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_PREFIX: begin
                if (!byte_avail_s) begin
                    overrun_s = 1'b1;
                end else if (pfx_bit_s != 6'd0) begin
                    // A REX only counts when it directly precedes the opcode.
                    mask_n   = mask_r | pfx_bit_s;
                    rex_n    = 4'd0;
                    ptr_n    = ptr_r + PTR_ONE;
                    pcount_n = pcount_r + ONE_PW;
                    if ((pcount_r + ONE_PW) > MAX_EXT) begin
                        illegal_n = 1'b1;
                        state_n   = ST_DONE;
                    end else begin
                        state_n = ST_PREFIX;
                    end
                end else if (cur_byte_s[7:4] == 4'h4) begin
                    rex_n = cur_byte_s[3:0];
                    ptr_n = ptr_r + PTR_ONE;
                end else begin
                    state_n = ST_OPCODE;
                end
            end
            ST_OPCODE: begin
                if (!byte_avail_s) begin
                    overrun_s = 1'b1;
                end else if (cur_byte_s == 8'h0F) begin
                    opcode_n = 9'h100;
                    ptr_n    = ptr_r + PTR_ONE;
                    state_n  = ST_OPCODE2;
                end else begin
                    opcode_n = {1'b0, cur_byte_s};
                    ptr_n    = ptr_r + PTR_ONE;
                    imm_n    = opc_class_s.imm;
                    if (!opc_class_s.legal) begin
                        illegal_n = 1'b1;
                        state_n   = ST_DONE;
                    end else if (opc_class_s.has_modrm) begin
                        state_n = ST_MODRM;
                    end else begin
                        state_n = after_operands(4'd0, opc_class_s.imm);
                    end
                end
            end
            ST_OPCODE2: begin
                if (!byte_avail_s) begin
                    overrun_s = 1'b1;
                end else begin
                    opcode_n = {1'b1, cur_byte_s};
                    ptr_n    = ptr_r + PTR_ONE;
                    if (cur_byte_s[7:4] == 4'h8) begin
                        imm_n   = 4'd4;
                        state_n = ST_IMM;
                    end else if (cur_byte_s == 8'h05) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_MODRM;
                    end
                end
            end
            ST_MODRM: begin
                if (!byte_avail_s) begin
                    overrun_s = 1'b1;
                end else begin
                    modrm_n = cur_byte_s;
                    ptr_n   = ptr_r + PTR_ONE;
                    disp_n  = modrm_disp_s;
                    if ((cur_byte_s[7:6] != 2'b11) && (cur_byte_s[2:0] == 3'b100)) begin
                        state_n = ST_SIB;
                    end else begin
                        state_n = after_operands(modrm_disp_s, imm_r);
                    end
                end
            end
            ST_SIB: begin
                if (!byte_avail_s) begin
                    overrun_s = 1'b1;
                end else begin
                    ptr_n   = ptr_r + PTR_ONE;
                    disp_n  = sib_disp_s;
                    state_n = after_operands(sib_disp_s, imm_r);
                end
            end
            ST_DISP: begin
                if (disp_end_s > WIN_EXT) begin
                    overrun_s = 1'b1;
                end else begin
                    ptr_n   = disp_end_s[LEN_W-1:0];
                    state_n = after_operands(4'd0, imm_r);
                end
            end
            ST_IMM: begin
                if (imm_end_s > WIN_EXT) begin
                    overrun_s = 1'b1;
                end else begin
                    ptr_n   = imm_end_s[LEN_W-1:0];
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_DONE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        // Any field running past the window reports a full-window illegal.
        if (overrun_s) begin
            illegal_n = 1'b1;
            ptr_n     = WIN_EXT[LEN_W-1:0];
            state_n   = ST_DONE;
        end else begin
            illegal_n = illegal_n;
        end
    end

    // State and field registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            ptr_r     <= {LEN_W{1'b0}};
            pcount_r  <= {PW{1'b0}};
            mask_r    <= 6'd0;
            rex_r     <= 4'd0;
            opcode_r  <= 9'd0;
            modrm_r   <= 8'd0;
            illegal_r <= 1'b0;
            disp_r    <= 4'd0;
            imm_r     <= 4'd0;
        end else begin
            state_r   <= state_n;
            ptr_r     <= ptr_n;
            pcount_r  <= pcount_n;
            mask_r    <= mask_n;
            rex_r     <= rex_n;
            opcode_r  <= opcode_n;
            modrm_r   <= modrm_n;
            illegal_r <= illegal_n;
            disp_r    <= disp_n;
            imm_r     <= imm_n;
        end
    end

    // Window capture on accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WINDOW_BYTES; i++) begin
                win_r[i] <= 8'h00;
            end
        end else if ((state_r == ST_IDLE) && in_valid) begin
            for (int i = 0; i < WINDOW_BYTES; i++) begin
                win_r[i] <= in_bytes[8*i +: 8];
            end
        end
    end

    // Output registers: loaded on entry to DONE, cleared on the handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            out_len_r     <= {LEN_W{1'b0}};
            out_mask_r    <= 6'd0;
            out_rex_r     <= 4'd0;
            out_opcode_r  <= 9'd0;
            out_modrm_r   <= 8'd0;
            out_illegal_r <= 1'b0;
        end else begin
            in_ready_r <= (state_n == ST_IDLE);
            if ((state_r != ST_DONE) && (state_n == ST_DONE)) begin
                out_valid_r   <= 1'b1;
                out_len_r     <= ptr_n;
                out_mask_r    <= mask_n;
                out_rex_r     <= rex_n;
                out_opcode_r  <= opcode_n;
                out_modrm_r   <= modrm_n;
                out_illegal_r <= illegal_n;
            end else if ((state_r == ST_DONE) && (state_n == ST_IDLE)) begin
                out_valid_r   <= 1'b0;
                out_len_r     <= {LEN_W{1'b0}};
                out_mask_r    <= 6'd0;
                out_rex_r     <= 4'd0;
                out_opcode_r  <= 9'd0;
                out_modrm_r   <= 8'd0;
                out_illegal_r <= 1'b0;
            end
        end
    end

    assign in_ready        = in_ready_r;
    assign out_valid       = out_valid_r;
    assign out_len         = out_len_r;
    assign out_prefix_mask = out_mask_r;
    assign out_rex         = out_rex_r;
    assign out_opcode      = out_opcode_r;
    assign out_modrm       = out_modrm_r;
    assign out_illegal     = out_illegal_r;

endmodule

// File: tb/tb_x86_length_decoder.sv
// Directed bench for x86_length_decoder. Expected results come from a
// byte-scanning reference decoder written with plain integers; a per-cycle
// compare process checks the held result, and a few literal values pin the
// reference itself.
module tb_x86_length_decoder;

    logic         clk;
    logic         reset;
    logic [0:119] in_bytes;
    logic         in_valid;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   out_len;
    logic [5:0]   out_prefix_mask;
    logic [3:0]   out_rex;
    logic [8:0]   out_opcode;
    logic [7:0]   out_modrm;
    logic         out_illegal;

    x86_length_decoder dut (
        .clk             (clk),
        .reset           (reset),
        .in_bytes        (in_bytes),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_len         (out_len),
        .out_prefix_mask (out_prefix_mask),
        .out_rex         (out_rex),
        .out_opcode      (out_opcode),
        .out_modrm       (out_modrm),
        .out_illegal     (out_illegal)
    );

    typedef struct {
        int         len;
        logic [5:0] mask;
        logic [3:0] rex;
        logic [8:0] opc;
        logic [7:0] modrm;
        logic       ill;
        bit         len_chk;
        int         lat;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    bit   exp_active = 1'b0;
    exp_t cur_exp;
    int   cap_len, cap_mask, cap_rex, cap_opc, cap_modrm, cap_ill, cap_lat;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [5:0] pfx_bit(input logic [7:0] b);
        if (b == 8'hF0) return 6'b000001;
        if (b == 8'hF2) return 6'b000010;
        if (b == 8'hF3) return 6'b000100;
        if (b inside {8'h2E, 8'h36, 8'h3E, 8'h26, 8'h64, 8'h65}) return 6'b001000;
        if (b == 8'h66) return 6'b010000;
        if (b == 8'h67) return 6'b100000;
        return 6'b000000;
    endfunction

    function automatic exp_t overrun(input exp_t e_in);
        exp_t e;
        e = e_in;
        e.ill = 1'b1;
        e.len = 15;
        e.len_chk = 1'b1;
        return e;
    endfunction

    // Reference decoder: p is the byte position, lat the cycles spent walking.
    function automatic exp_t model(input logic [7:0] w [15]);
        exp_t e;
        int p, np, disp, imm;
        bit mrm;
        logic [7:0] b;
        logic [5:0] pb;
        e.len = 0; e.mask = 6'd0; e.rex = 4'd0; e.opc = 9'd0; e.modrm = 8'd0;
        e.ill = 1'b0; e.len_chk = 1'b1; e.lat = 0;
        p = 0; np = 0; disp = 0; imm = 0; mrm = 1'b0;
        while (1) begin
            if (p >= 15) begin e.lat++; return overrun(e); end
            b = w[p];
            pb = pfx_bit(b);
            if (pb != 6'd0) begin
                e.mask |= pb; e.rex = 4'd0; np++; p++; e.lat++;
                if (np > 4) begin e.ill = 1'b1; e.len_chk = 1'b0; return e; end
            end else if (b >= 8'h40 && b <= 8'h4F) begin
                e.rex = b[3:0]; p++; e.lat++;
            end else begin
                break;
            end
        end
        e.lat++;
        b = w[p]; p++; e.lat++;
        if (b == 8'h0F) begin
            if (p >= 15) begin e.lat++; return overrun(e); end
            b = w[p]; p++; e.lat++;
            e.opc = {1'b1, b};
            if (b >= 8'h80 && b <= 8'h8F) imm = 4;
            else if (b == 8'h05) imm = 0;
            else mrm = 1'b1;
        end else begin
            e.opc = {1'b0, b};
            if (b <= 8'h3F && b[2:0] <= 3'd3) mrm = 1'b1;
            else if (b <= 8'h3F && b[2:0] == 3'd4) imm = 1;
            else if (b <= 8'h3F && b[2:0] == 3'd5) imm = e.mask[4] ? 2 : 4;
            else if (b == 8'h80 || b == 8'h83 || b == 8'hC6) begin mrm = 1'b1; imm = 1; end
            else if (b == 8'h81 || b == 8'hC7) begin mrm = 1'b1; imm = e.mask[4] ? 2 : 4; end
            else if ((b >= 8'h88 && b <= 8'h8B) || b == 8'h8D) mrm = 1'b1;
            else if (b >= 8'hB0 && b <= 8'hB7) imm = 1;
            else if (b >= 8'hB8 && b <= 8'hBF) imm = e.rex[3] ? 8 : (e.mask[4] ? 2 : 4);
            else if ((b >= 8'h70 && b <= 8'h7F) || b == 8'hEB) imm = 1;
            else if (b == 8'hE8 || b == 8'hE9) imm = 4;
            else if ((b >= 8'h50 && b <= 8'h5F) || b == 8'h90 || b == 8'hC3) imm = 0;
            else begin e.ill = 1'b1; e.len_chk = 1'b0; return e; end
        end
        if (mrm) begin
            if (p >= 15) begin e.lat++; return overrun(e); end
            b = w[p]; p++; e.lat++;
            e.modrm = b;
            if (b[7:6] == 2'd1) disp = 1;
            else if (b[7:6] == 2'd2) disp = 4;
            else if (b[7:6] == 2'd0 && b[2:0] == 3'd5) disp = 4;
            if (b[7:6] != 2'd3 && b[2:0] == 3'd4) begin
                if (p >= 15) begin e.lat++; return overrun(e); end
                b = w[p]; p++; e.lat++;
                if (b[2:0] == 3'd5 && e.modrm[7:6] == 2'd0) disp = 4;
            end
        end
        if (disp > 0) begin e.lat++; if (p + disp > 15) return overrun(e); p += disp; end
        if (imm > 0) begin e.lat++; if (p + imm > 15) return overrun(e); p += imm; end
        e.len = p;
        return e;
    endfunction

    // Per-cycle comparison of the held result against the reference.
    always @(negedge clk) begin
        if (exp_active) begin
            check("out_valid", 32'(out_valid), 32'd1);
            check("in_ready_busy", 32'(in_ready), 32'd0);
            if (cur_exp.len_chk) check("out_len", 32'(out_len), 32'(cur_exp.len));
            check("out_prefix_mask", 32'(out_prefix_mask), 32'(cur_exp.mask));
            check("out_rex", 32'(out_rex), 32'(cur_exp.rex));
            check("out_opcode", 32'(out_opcode), 32'(cur_exp.opc));
            check("out_modrm", 32'(out_modrm), 32'(cur_exp.modrm));
            check("out_illegal", 32'(out_illegal), 32'(cur_exp.ill));
        end
    end

    // v holds n bytes, first byte most significant; remaining window bytes are 00.
    task automatic run(input logic [119:0] v, input int n, input int hold);
        logic [119:0] al;
        logic [7:0]   w [15];
        int           cnt;
        al = v << (8 * (15 - n));
        for (int i = 0; i < 15; i++) w[i] = al[119 - 8*i -: 8];
        cur_exp = model(w);
        for (int k = 0; k < 10 && !in_ready; k++) begin @(posedge clk); #1; end
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_bytes = al;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 40) begin @(posedge clk); #1; cnt++; end
        check("valid_seen", 32'(out_valid), 32'd1);
        check("latency", 32'(cnt), 32'(cur_exp.lat));
        cap_len = out_len; cap_mask = out_prefix_mask; cap_rex = out_rex;
        cap_opc = out_opcode; cap_modrm = out_modrm; cap_ill = out_illegal; cap_lat = cnt;
        exp_active = out_valid;
        repeat (hold) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_active = 1'b0;
        check("post_hs_valid", 32'(out_valid), 32'd0);
        check("post_hs_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stale;
        clk = 1'b0; reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_bytes = '0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_len", 32'(out_len), 32'd0);
        check("rst_out_opcode", 32'(out_opcode), 32'd0);
        check("rst_out_illegal", 32'(out_illegal), 32'd0);
        check("rst_out_rex", 32'(out_rex), 32'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        run({8'h90}, 1, 0);
        check("pin_nop_len", 32'(cap_len), 32'd1);
        check("pin_nop_opc", 32'(cap_opc), 32'h090);
        check("pin_nop_lat", 32'(cap_lat), 32'd2);
        check("pin_nop_mask", 32'(cap_mask), 32'd0);

        run({8'h48, 8'hB8, 64'h0102030405060708}, 10, 0);
        check("pin_movabs_len", 32'(cap_len), 32'd10);
        check("pin_movabs_rex", 32'(cap_rex), 32'h8);
        check("pin_movabs_opc", 32'(cap_opc), 32'h0B8);

        run({8'h66, 8'hF0, 8'h81, 8'h84, 8'h24, 32'h44332211, 16'hBBAA}, 11, 0);
        check("pin_sib_len", 32'(cap_len), 32'd11);
        check("pin_sib_mask", 32'(cap_mask), 32'b010001);
        check("pin_sib_modrm", 32'(cap_modrm), 32'h84);

        run({8'h0F, 8'h85, 32'h0}, 6, 5);
        check("pin_jcc_len", 32'(cap_len), 32'd6);
        check("pin_jcc_opc", 32'(cap_opc), 32'h185);

        run({40'h2E2E2E2E2E, 8'h90}, 6, 0);
        check("pin_pfx_overflow_ill", 32'(cap_ill), 32'd1);

        run({8'h06}, 1, 0);
        check("pin_bad_opc_ill", 32'(cap_ill), 32'd1);

        run({40'h4040404040, 8'h48, 8'hB8, 64'h1122334455667788}, 15, 0);
        check("pin_full_window_len", 32'(cap_len), 32'd15);
        check("pin_full_window_ill", 32'(cap_ill), 32'd0);

        run({48'h404040404040, 8'h48, 8'hB8, 56'h11223344556677}, 15, 0);
        check("pin_overrun_ill", 32'(cap_ill), 32'd1);
        check("pin_overrun_len", 32'(cap_len), 32'd15);

        run({8'h8B, 8'h05, 32'h78563412}, 6, 0);
        run({8'h83, 8'h44, 8'h24, 8'h08, 8'h01}, 5, 0);
        check("pin_disp8_sib_len", 32'(cap_len), 32'd5);
        run({8'h66, 8'hB8, 16'h3412}, 4, 0);
        run({8'h0F, 8'h05}, 2, 0);
        run({8'h0F, 8'hB6, 8'hC0}, 3, 1);
        run({8'h8B, 8'h04, 8'h25, 32'h0}, 7, 0);
        check("pin_sib_nobase_len", 32'(cap_len), 32'd7);
        run({8'h48, 8'h66, 8'hB8, 16'h3412}, 5, 0);
        check("pin_rex_cleared", 32'(cap_rex), 32'd0);
        run({8'hC3}, 1, 2);

        // Abort a decode with reset one cycle after the accept.
        in_bytes = {8'h48, 8'hC7, 8'h80, 32'h0, 32'h0, 48'h0};
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        stale = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("abort_no_stale", 32'(stale), 32'd0);
        check("abort_idle_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        run({8'h90}, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
